maze_port_sched: RTL and testbench
==================================

# maze_port_sched

Schedules the single maze bitmap memory port between the maze solver and a host load/readback port. Starts the solver on command and stalls it with a clock-enable while the host owns the port. Holds solver read data across stalls so the solver sees a seamless memory. Counts path marks written and reports completion. Sits between the solver, the host bus adapter and the 2-bit-per-cell maze RAM.

## Interface
- maze_width, 6, row/col index width (maze is 2^maze_width square)
- max_wait, 4, max consecutive cycles a pending host request waits while the solver runs (≥1)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse: begin solving (honoured only in IDLE)
- s_row, s_col  in  maze_width  solver address
- s_oe, s_we  in  1  solver read / write request
- s_done  in  1  solver found exit
- s_in  out  1  wall bit to solver (1 = cell is WALL)
- s_en  out  1  solver state-register enable
- h_req, h_we  in  1  host request, host write (else read)
- h_row, h_col  in  maze_width  host address
- h_wdata  in  2  host write cell code
- h_gnt  out  1  host transfer performed this cycle
- h_rvalid  out  1  h_rdata valid (cycle after granted read)
- h_rdata  out  2  host read cell code
- m_row, m_col  out  maze_width  RAM address
- m_oe, m_we  out  1  RAM read / write strobe
- m_wdata  out  2  RAM write data
- m_rdata  in  2  RAM read data, valid cycle after m_oe
- busy  out  1  state is SOLVE or HOST
- done  out  1  solver finished; sticky until rst
- steps  out  16  count of solver writes, saturates at 16'hFFFF

## Operation
- Cell codes: FREE=0, WALL=1, PATH=2. Solver write stores PATH; s_in = (cell == WALL).
- States IDLE, SOLVE, HOST, DONE; reset → IDLE.
- IDLE: s_en=0; host owns port; h_gnt=h_req. start → SOLVE.
- SOLVE: s_en=1; port driven by s_*; h_gnt=0. wait_cnt increments each cycle h_req=1, clears when h_req=0. h_req && wait_cnt==max_wait-1 → HOST. s_done → DONE (takes priority over HOST).
- HOST: s_en=0; port driven by host; h_gnt=h_req; wait_cnt cleared; → SOLVE next cycle (exactly one host transfer per slot). s_done is not sampled.
- DONE: s_en=0, done=1, host owns port as in IDLE; start ignored; only rst leaves.
- A stalled solver holds its state and replays its identical request next enabled cycle; no solver access is lost or duplicated.
- Read hold: s_hold <= s_in every cycle. s_in = (m_rdata==WALL) if the previous cycle was a solver-owned m_oe, else s_hold.
- steps increments on each solver-owned m_we while below 16'hFFFF.
- Host writes during SOLVE (via HOST slot) are permitted; the solver sees them on later reads.

## Timing
- Reset values: s_en=0, s_in=0, h_gnt=0, h_rvalid=0, h_rdata=0, m_oe=0, m_we=0, m_row=m_col=0, m_wdata=0, busy=0, done=0, steps=0. RAM contents unaffected.
- rst mid-SOLVE/HOST: next cycle IDLE; counters, hold register and wait_cnt cleared.
- h_gnt is combinational in the request cycle. h_rvalid/h_rdata follow a granted read by 1 cycle.
- start → s_en=1 on next cycle. Host worst-case latency in SOLVE: max_wait+1 cycles.
- start and h_req in the same IDLE cycle: host granted this cycle; SOLVE next.

## Structure
- maze_pkg: cell codes FREE/WALL/PATH, state enum, STEPS_W=16.
- Sub-module maze_starve_cnt: wait counter with clear and max_wait compare output.

## Test plan
- start with empty host traffic; solver reads (2,3)=WALL → s_in=1 the cycle after s_oe; steps counts writes.
- h_req held continuously during SOLVE, max_wait=4 → HOST entered after 4 waiting cycles; s_en=0 exactly 1 cycle; h_gnt once.
- Solver read at t, HOST at t+1 → s_in at t+2 equals the WALL bit read at t, not the host data.
- Host write WALL at (5,5) in IDLE, read back → h_rvalid=1, h_rdata=1 next cycle.
- s_done and starve threshold in same cycle → DONE, done=1, host granted freely after.
- rst asserted in HOST state → IDLE next cycle, all outputs at reset values, steps=0.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared definitions for the maze memory port scheduler: cell codes,
// scheduler states and counter widths.
package maze_pkg;

    localparam int STEPS_W = 16;

    typedef enum logic [1:0] {
        FREE = 2'd0,
        WALL = 2'd1,
        PATH = 2'd2
    } cell_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SOLVE = 2'd1,
        ST_HOST  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/maze_starve_cnt.sv
// Counts consecutive cycles a host request has been kept waiting and flags
// when the next waiting cycle must be handed to the host.
module maze_starve_cnt #(
    parameter int max_wait = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic at_max_o
);

    localparam int CW = (max_wait > 1) ? $clog2(max_wait) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign at_max_o = (cnt_q == CW'(max_wait - 1));

    // Holds at the threshold; the scheduler leaves SOLVE once it is reached.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !at_max_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/maze_port_sched.sv
// Shares one maze RAM port between the solver and the host, stalling the
// solver with s_en while the host owns the port.
module maze_port_sched
    import maze_pkg::*;
#(
    parameter int maze_width = 6,
    parameter int max_wait   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [maze_width-1:0] s_row,
    input  logic [maze_width-1:0] s_col,
    input  logic                  s_oe,
    input  logic                  s_we,
    input  logic                  s_done,
    output logic                  s_in,
    output logic                  s_en,
    input  logic                  h_req,
    input  logic                  h_we,
    input  logic [maze_width-1:0] h_row,
    input  logic [maze_width-1:0] h_col,
    input  logic [1:0]            h_wdata,
    output logic                  h_gnt,
    output logic                  h_rvalid,
    output logic [1:0]            h_rdata,
    output logic [maze_width-1:0] m_row,
    output logic [maze_width-1:0] m_col,
    output logic                  m_oe,
    output logic                  m_we,
    output logic [1:0]            m_wdata,
    input  logic [1:0]            m_rdata,
    output logic                  busy,
    output logic                  done,
    output logic [STEPS_W-1:0]    steps
);

    state_t               state_q, state_d;
    logic                 sol_rd_q;
    logic                 s_hold_q;
    logic                 h_rvalid_q;
    logic [STEPS_W-1:0]   steps_q, steps_d;
    logic                 solver_owns;
    logic                 wait_inc;
    logic                 wait_at_max;

    assign solver_owns = (state_q == ST_SOLVE);
    assign wait_inc    = solver_owns && h_req;

    maze_starve_cnt #(
        .max_wait (max_wait)
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (!wait_inc),
        .inc_i    (wait_inc),
        .at_max_o (wait_at_max)
    );

    // Solver completion wins over a due host slot.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_SOLVE;
            ST_SOLVE: begin
                if (s_done) begin
                    state_d = ST_DONE;
                end else if (h_req && wait_at_max) begin
                    state_d = ST_HOST;
                end
            end
            ST_HOST:  state_d = ST_SOLVE;
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        m_row   = '0;
        m_col   = '0;
        m_oe    = 1'b0;
        m_we    = 1'b0;
        m_wdata = FREE;
        h_gnt   = 1'b0;
        if (solver_owns) begin
            m_row   = s_row;
            m_col   = s_col;
            m_oe    = s_oe;
            m_we    = s_we;
            m_wdata = PATH;
        end else if (h_req) begin
            h_gnt   = 1'b1;
            m_row   = h_row;
            m_col   = h_col;
            m_oe    = !h_we;
            m_we    = h_we;
            m_wdata = h_wdata;
        end
    end

    always_comb begin
        steps_d = steps_q;
        if (solver_owns && s_we && (steps_q != '1)) begin
            steps_d = steps_q + 1'b1;
        end
    end

    // Fresh RAM data only when the solver issued last cycle's read; otherwise replay the held bit.
    assign s_in     = sol_rd_q ? (m_rdata == WALL) : s_hold_q;
    assign s_en     = solver_owns;
    assign h_rvalid = h_rvalid_q;
    assign h_rdata  = h_rvalid_q ? m_rdata : 2'b00;
    assign busy     = (state_q == ST_SOLVE) || (state_q == ST_HOST);
    assign done     = (state_q == ST_DONE);
    assign steps    = steps_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sol_rd_q   <= 1'b0;
            s_hold_q   <= 1'b0;
            h_rvalid_q <= 1'b0;
            steps_q    <= '0;
        end else begin
            state_q    <= state_d;
            sol_rd_q   <= solver_owns && s_oe;
            s_hold_q   <= s_in;
            h_rvalid_q <= h_gnt && !h_we;
            steps_q    <= steps_d;
        end
    end

endmodule

// File: tb/tb_maze_port_sched.sv
// Bench for maze_port_sched with a behavioural maze RAM and a host read
// scoreboard.
module tb_maze_port_sched;

    localparam int MW = 6;
    localparam int MWAIT = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [MW-1:0] s_row = '0, s_col = '0;
    logic          s_oe = 1'b0, s_we = 1'b0, s_done = 1'b0;
    logic          s_in, s_en;
    logic          h_req = 1'b0, h_we = 1'b0;
    logic [MW-1:0] h_row = '0, h_col = '0;
    logic [1:0]    h_wdata = 2'd0;
    logic          h_gnt, h_rvalid;
    logic [1:0]    h_rdata;
    logic [MW-1:0] m_row, m_col;
    logic          m_oe, m_we;
    logic [1:0]    m_wdata;
    logic [1:0]    m_rdata = 2'd0;
    logic          busy, done;
    logic [15:0]   steps;

    int checks = 0;
    int failures = 0;
    logic [1:0] sb[$];
    logic [1:0] mem [0:(1<<(2*MW))-1];

    always #5 clk = ~clk;

    maze_port_sched #(.maze_width(MW), .max_wait(MWAIT)) dut (
        .clk(clk), .rst(rst), .start(start),
        .s_row(s_row), .s_col(s_col), .s_oe(s_oe), .s_we(s_we), .s_done(s_done),
        .s_in(s_in), .s_en(s_en),
        .h_req(h_req), .h_we(h_we), .h_row(h_row), .h_col(h_col), .h_wdata(h_wdata),
        .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
        .m_row(m_row), .m_col(m_col), .m_oe(m_oe), .m_we(m_we), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .busy(busy), .done(done), .steps(steps)
    );

    // Maze RAM: write-through storage, registered read data.
    always @(posedge clk) begin
        if (m_we) mem[{m_row, m_col}] <= m_wdata;
        if (m_oe) m_rdata <= mem[{m_row, m_col}];
    end

    // Host read scoreboard.
    always @(negedge clk) begin
        if (h_rvalid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_rvalid: h_rvalid with no read outstanding, h_rdata=%0d", h_rdata);
            end else begin
                logic [1:0] exp;
                exp = sb.pop_front();
                if (h_rdata !== exp) begin
                    failures++;
                    $display("FAIL sb_rdata: got %0d expected %0d", h_rdata, exp);
                end
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        nxt();
        nxt();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || s_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: busy=%b done=%b s_en=%b expected 0", busy, done, s_en);
        end
        checks++;
        if (steps !== 16'd0) begin
            failures++;
            $display("FAIL reset_steps: got %0d expected 0", steps);
        end
        checks++;
        if ({h_gnt, h_rvalid, h_rdata, m_oe, m_we, m_row, m_col, m_wdata, s_in} !== '0) begin
            failures++;
            $display("FAIL reset_outs: gnt=%b rv=%b rd=%0d oe=%b we=%b row=%0d col=%0d wd=%0d s_in=%b expected 0",
                     h_gnt, h_rvalid, h_rdata, m_oe, m_we, m_row, m_col, m_wdata, s_in);
        end
        nxt();
    endtask

    task automatic test_host_idle();
        h_req = 1'b1; h_we = 1'b1; h_row = 6'd5; h_col = 6'd5; h_wdata = 2'd1;
        @(negedge clk);
        checks++;
        if (h_gnt !== 1'b1 || m_we !== 1'b1 || m_row !== 6'd5 || m_wdata !== 2'd1) begin
            failures++;
            $display("FAIL idle_write: gnt=%b m_we=%b m_row=%0d m_wdata=%0d expected 1 1 5 1",
                     h_gnt, m_we, m_row, m_wdata);
        end
        nxt();
        h_we = 1'b0;
        sb.push_back(2'd1);
        @(negedge clk);
        checks++;
        if (h_gnt !== 1'b1 || m_oe !== 1'b1) begin
            failures++;
            $display("FAIL idle_read_gnt: gnt=%b m_oe=%b expected 1 1", h_gnt, m_oe);
        end
        nxt();
        h_req = 1'b0;
        @(negedge clk);
        checks++;
        if (h_rvalid !== 1'b1) begin
            failures++;
            $display("FAIL idle_rvalid: got %b expected 1", h_rvalid);
        end
        nxt();
    endtask

    task automatic test_solve_read();
        start = 1'b1;
        nxt();
        start = 1'b0;
        s_oe = 1'b1; s_row = 6'd2; s_col = 6'd3;
        @(negedge clk);
        checks++;
        if (s_en !== 1'b1 || busy !== 1'b1 || m_oe !== 1'b1 || m_row !== 6'd2 || m_col !== 6'd3) begin
            failures++;
            $display("FAIL solve_start: s_en=%b busy=%b m_oe=%b row=%0d col=%0d expected 1 1 1 2 3",
                     s_en, busy, m_oe, m_row, m_col);
        end
        nxt();
        s_oe = 1'b0;
        @(negedge clk);
        checks++;
        if (s_in !== 1'b1) begin
            failures++;
            $display("FAIL solve_wall: s_in=%b expected 1", s_in);
        end
        nxt();
        @(negedge clk);
        checks++;
        if (s_in !== 1'b1) begin
            failures++;
            $display("FAIL solve_hold: s_in=%b expected 1", s_in);
        end
        nxt();
        s_oe = 1'b1; s_row = 6'd0; s_col = 6'd0;
        nxt();
        s_oe = 1'b0;
        @(negedge clk);
        checks++;
        if (s_in !== 1'b0) begin
            failures++;
            $display("FAIL solve_free: s_in=%b expected 0", s_in);
        end
        for (int i = 0; i < 3; i++) begin
            nxt();
            s_we = 1'b1; s_row = 6'd7; s_col = 6'(i);
        end
        nxt();
        s_we = 1'b0;
        @(negedge clk);
        checks++;
        if (steps !== 16'd3) begin
            failures++;
            $display("FAIL solve_steps: got %0d expected 3", steps);
        end
        checks++;
        if (mem[{6'd7, 6'd2}] !== 2'd2) begin
            failures++;
            $display("FAIL solve_path: cell(7,2)=%0d expected 2", mem[{6'd7, 6'd2}]);
        end
        nxt();
    endtask

    task automatic test_starve();
        int gnts;
        gnts = 0;
        h_req = 1'b1; h_we = 1'b0; h_row = 6'd5; h_col = 6'd5;
        for (int i = 0; i < 6; i++) begin
            logic exp_en, exp_g;
            exp_en = (i != 4);
            exp_g  = (i == 4);
            if (i == 4) sb.push_back(2'd1);
            @(negedge clk);
            if (h_gnt === 1'b1) gnts++;
            checks++;
            if (s_en !== exp_en || h_gnt !== exp_g) begin
                failures++;
                $display("FAIL starve_cyc%0d: s_en=%b h_gnt=%b expected %b %b", i, s_en, h_gnt, exp_en, exp_g);
            end
            nxt();
        end
        checks++;
        if (gnts != 1) begin
            failures++;
            $display("FAIL starve_gnt_count: got %0d expected 1", gnts);
        end
        h_req = 1'b0;
        nxt();
    endtask

    task automatic test_read_hold();
        h_we = 1'b0; h_row = 6'd0; h_col = 6'd0;
        for (int i = 0; i < 6; i++) begin
            h_req = (i < 5);
            s_oe  = (i == 3) || (i == 4);
            s_row = 6'd2; s_col = 6'd3;
            if (i == 4) sb.push_back(2'd0);
            @(negedge clk);
            if (i == 4) begin
                checks++;
                if (s_en !== 1'b0 || h_gnt !== 1'b1 || s_in !== 1'b1) begin
                    failures++;
                    $display("FAIL hold_host: s_en=%b h_gnt=%b s_in=%b expected 0 1 1", s_en, h_gnt, s_in);
                end
            end
            if (i == 5) begin
                checks++;
                if (s_in !== 1'b1 || s_en !== 1'b1) begin
                    failures++;
                    $display("FAIL hold_after_host: s_in=%b s_en=%b expected 1 1", s_in, s_en);
                end
            end
            nxt();
        end
        s_oe = 1'b0;
        nxt();
    endtask

    task automatic test_done_priority();
        h_req = 1'b1; h_we = 1'b0; h_row = 6'd5; h_col = 6'd5;
        for (int i = 0; i < 4; i++) begin
            s_done = (i == 3);
            @(negedge clk);
            checks++;
            if (h_gnt !== 1'b0) begin
                failures++;
                $display("FAIL done_wait%0d: h_gnt=%b expected 0", i, h_gnt);
            end
            nxt();
        end
        s_done = 1'b0;
        sb.push_back(2'd1);
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || s_en !== 1'b0 || busy !== 1'b0 || h_gnt !== 1'b1) begin
            failures++;
            $display("FAIL done_enter: done=%b s_en=%b busy=%b h_gnt=%b expected 1 0 0 1",
                     done, s_en, busy, h_gnt);
        end
        nxt();
        h_req = 1'b0;
        start = 1'b1;
        nxt();
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || s_en !== 1'b0 || steps !== 16'd3) begin
            failures++;
            $display("FAIL done_sticky: done=%b s_en=%b steps=%0d expected 1 0 3", done, s_en, steps);
        end
        nxt();
    endtask

    task automatic test_reset_in_host();
        do_reset();
        start = 1'b1; h_req = 1'b1; h_we = 1'b0; h_row = 6'd5; h_col = 6'd5;
        sb.push_back(2'd1);
        @(negedge clk);
        checks++;
        if (h_gnt !== 1'b1) begin
            failures++;
            $display("FAIL start_with_host: h_gnt=%b expected 1", h_gnt);
        end
        nxt();
        start = 1'b0;
        h_we = 1'b1; h_row = 6'd9; h_col = 6'd9; h_wdata = 2'd1;
        s_we = 1'b1; s_row = 6'd10; s_col = 6'd10;
        @(negedge clk);
        checks++;
        if (s_en !== 1'b1 || h_gnt !== 1'b0) begin
            failures++;
            $display("FAIL start_solve: s_en=%b h_gnt=%b expected 1 0", s_en, h_gnt);
        end
        nxt();
        s_we = 1'b0;
        @(negedge clk);
        checks++;
        if (steps !== 16'd1) begin
            failures++;
            $display("FAIL host_steps: got %0d expected 1", steps);
        end
        nxt();
        nxt();
        nxt();
        @(negedge clk);
        checks++;
        if (s_en !== 1'b0 || h_gnt !== 1'b1 || m_we !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL host_slot: s_en=%b h_gnt=%b m_we=%b busy=%b expected 0 1 1 1",
                     s_en, h_gnt, m_we, busy);
        end
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        h_req = 1'b0; h_we = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || s_en !== 1'b0 || steps !== 16'd0 ||
            {h_gnt, h_rvalid, h_rdata, m_oe, m_we, m_row, m_col, m_wdata, s_in} !== '0) begin
            failures++;
            $display("FAIL rst_in_host: busy=%b done=%b s_en=%b steps=%0d gnt=%b rv=%b s_in=%b expected all 0",
                     busy, done, s_en, steps, h_gnt, h_rvalid, s_in);
        end
        checks++;
        if (mem[{6'd9, 6'd9}] !== 2'd1) begin
            failures++;
            $display("FAIL host_write_solve: cell(9,9)=%0d expected 1", mem[{6'd9, 6'd9}]);
        end
        nxt();
    endtask

    initial begin
        for (int i = 0; i < (1 << (2*MW)); i++) mem[i] = 2'd0;
        mem[{6'd2, 6'd3}] = 2'd1;
        test_reset();
        test_host_idle();
        test_solve_read();
        test_starve();
        test_read_hold();
        test_done_priority();
        test_reset_in_host();
        nxt();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: %0d host reads never returned, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
